// File: rtl/hamming_uart_pkg.sv
// Shared definitions for the Hamming(7,4) UART link: FSM encodings, widths and the encoder function.
package hamming_uart_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_e;

  // Codeword bit order: {d3, d2, d1, p3, d0, p2, p1}
  function automatic logic [CODE_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

endpackage

// File: rtl/hamming_uart_tx_if.sv
// Nibble handshake between the upstream source and the Hamming UART transmitter.
interface hamming_uart_tx_if;
  import hamming_uart_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic [2:0]        inject_err;

  modport master (output data_in, output valid_in, output inject_err, input ready_out);
  modport slave  (input data_in, input valid_in, input inject_err, output ready_out);

endinterface

// File: rtl/hamming_encoder_74.sv
// Combinational Hamming(7,4) encoder; also serves as the decoder bench's reference model.
module hamming_encoder_74
  import hamming_uart_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] code
);

  assign code = hamming74_encode(data);

endmodule

// File: rtl/hamming_uart_tx.sv
// Hamming(7,4) UART transmitter: encodes a nibble, optionally flips one bit, sends start + 7 bits LSB-first + stop.
module hamming_uart_tx
  import hamming_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  hamming_uart_tx_if.slave    bus,
  output logic                tx,
  output logic                busy,
  output logic [1:0]          state_out,
  output logic [CODE_W-1:0]   codeword_out
);

  localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      IDX_LAST = 3'd6;

  tx_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [CODE_W-1:0] shreg;
  logic [CODE_W-1:0] enc_code;
  logic [CODE_W-1:0] inj_mask;
  logic [CODE_W-1:0] frame_code;
  logic              handshake;
  logic              bit_done;

  hamming_encoder_74 u_enc (
    .data (bus.data_in),
    .code (enc_code)
  );

  // Position p (1..7) maps to codeword bit p-1; zero means no error
  assign inj_mask   = (bus.inject_err == 3'd0) ? '0 : (CODE_W'(1) << (bus.inject_err - 3'd1));
  assign frame_code = enc_code ^ inj_mask;

  assign bus.ready_out = (state == IDLE) && ena;
  assign handshake     = bus.valid_in && bus.ready_out;
  assign bit_done      = (cnt == CNT_LAST);
  assign state_out     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      codeword_out <= '0;
      tx           <= 1'b1;
      busy         <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (handshake) begin
            state        <= START;
            cnt          <= '0;
            shreg        <= frame_code;
            codeword_out <= frame_code;
            tx           <= 1'b0;
            busy         <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state <= DATA;
            cnt   <= '0;
            idx   <= '0;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Scoreboard bench for hamming_uart_tx: a serial-line monitor decodes each frame and checks it against queued expectations.
module tb_hamming_uart_tx;
  import hamming_uart_pkg::*;

  localparam int unsigned C     = 4;
  localparam int          FRAME = 9 * C;

  typedef struct packed {
    logic [6:0] code;
    logic [3:0] data;
    logic [2:0] syn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       tx;
  logic       busy;
  logic [1:0] state_out;
  logic [6:0] codeword_out;

  hamming_uart_tx_if bus ();

  hamming_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .bus          (bus),
    .tx           (tx),
    .busy         (busy),
    .state_out    (state_out),
    .codeword_out (codeword_out)
  );

  always #5 clk = ~clk;

  // Hand-computed Hamming(7,4) codewords for nibbles 0..F
  logic [6:0] enc_tab [0:15] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                 7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};
  logic [3:0] bp_vals [0:7] = '{4'h3, 4'hC, 4'h5, 4'hA, 4'hE, 4'h1, 4'h8, 4'h7};

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic ena_q = 1'b0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ena_q <= ena;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Presents one nibble, waits for acceptance, queues the expected frame; returns the handshake cycle.
  task automatic send(input logic [3:0] d, input logic [2:0] inj, input logic [6:0] exp_code,
                      output int hs_cyc);
    int   n;
    exp_t e;
    bus.data_in    = d;
    bus.inject_err = inj;
    bus.valid_in   = 1'b1;
    n = 0;
    while (!bus.ready_out && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_out) begin
      check("ready_timeout", 32'(bus.ready_out), 32'd1);
      bus.valid_in = 1'b0;
      hs_cyc = -1;
      return;
    end
    e.code = exp_code;
    e.data = d;
    e.syn  = inj;
    sb.push_back(e);
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    check("codeword_latch", 32'(codeword_out), 32'(exp_code));
    check("busy_rise", 32'(busy), 32'd1);
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  // Serial monitor: counts only cycles the DUT was enabled, samples mid-bit, checks framing and decode.
  initial begin : monitor
    bit         in_frame;
    bit         have_exp;
    int         cnt;
    logic [8:0] bits;
    logic [6:0] c;
    logic [6:0] fixed;
    logic [2:0] s;
    exp_t       cur;
    in_frame = 1'b0;
    have_exp = 1'b0;
    cnt      = 0;
    bits     = '0;
    cur      = '0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (ena_q && state_out == 2'b01 && tx == 1'b0) begin
          in_frame = 1'b1;
          cnt      = 1;
          bits     = '1;
          if (sb.size() == 0) begin
            have_exp = 1'b0;
            total++;
            bad++;
            $display("FAIL unexpected_frame: got a frame start, expected none (cycle %0d)", cyc);
          end else begin
            have_exp = 1'b1;
            cur = sb.pop_front();
            check("codeword_out", 32'(codeword_out), 32'(cur.code));
          end
        end
      end else if (ena_q) begin
        cnt++;
      end
      if (in_frame) begin
        for (int b = 0; b < 9; b++)
          if (cnt == b * C + C / 2 + 1) bits[b] = tx;
        if (cnt == FRAME) begin
          in_frame = 1'b0;
          if (have_exp) begin
            c = bits[7:1];
            s = {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
            fixed = (s == 3'd0) ? c : (c ^ (7'd1 << (s - 3'd1)));
            check("start_bit", 32'(bits[0]), 32'd0);
            check("stop_bit", 32'(bits[8]), 32'd1);
            check("serial_code", 32'(c), 32'(cur.code));
            check("syndrome", 32'(s), 32'(cur.syn));
            check("decoded_data", 32'({fixed[6], fixed[5], fixed[4], fixed[2]}), 32'(cur.data));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int hs;
    int prev;
    int n;
    int hsn;
    int k;
    exp_t e;

    rst = 1'b1;
    ena = 1'b1;
    bus.valid_in   = 1'b0;
    bus.data_in    = '0;
    bus.inject_err = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_codeword", 32'(codeword_out), 32'd0);
    check("rst_ready", 32'(bus.ready_out), 32'd1);
    ena = 1'b0;
    #1;
    check("ready_follows_ena", 32'(bus.ready_out), 32'd0);
    ena = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // Encode sweep, back-to-back frames
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 3'd0, enc_tab[i], hs);
      if (i > 0) check("frame_period", 32'(hs - prev), 32'(FRAME + 1));
      prev = hs;
    end

    // Single-bit error injection
    send(4'hB, 3'd3, 7'h51, hs);
    send(4'h0, 3'd7, 7'h40, hs);

    // Backpressure: valid held high, data and inject_err churning every cycle
    bus.valid_in = 1'b1;
    hsn  = 0;
    k    = 0;
    prev = 0;
    while (hsn < 3 && k < 5 * FRAME) begin
      bus.data_in    = bp_vals[k % 8];
      bus.inject_err = bus.ready_out ? 3'd0 : 3'((k % 7) + 1);
      if (bus.ready_out) begin
        e.code = enc_tab[bus.data_in];
        e.data = bus.data_in;
        e.syn  = 3'd0;
        sb.push_back(e);
        if (hsn > 0) check("bp_period", 32'(cyc + 1 - prev), 32'(FRAME + 1));
        prev = cyc + 1;
        hsn++;
      end
      @(negedge clk);
      k++;
    end
    bus.valid_in   = 1'b0;
    bus.inject_err = 3'd0;
    check("bp_handshakes", 32'(hsn), 32'd3);

    // Freeze with ena low during data bit 3 (code 0x19 has bit 3 set)
    send(4'h2, 3'd0, 7'h19, hs);
    n = 0;
    while (cyc < hs + 4 * C + 1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("freeze_tx", 32'(tx), 32'd1);
      check("freeze_state", 32'(state_out), 32'd2);
    end
    ena = 1'b1;
    n = 0;
    while (busy && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("freeze_end_cycle", 32'(cyc), 32'(hs + FRAME + 10));

    // Reset mid-frame, then reset colliding with a handshake, then a clean frame
    send(4'h9, 3'd0, 7'h4C, hs);
    n = 0;
    while (cyc < hs + C + 2 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    rst            = 1'b1;
    bus.data_in    = 4'hD;
    bus.valid_in   = 1'b1;
    @(negedge clk);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_state", 32'(state_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_codeword", 32'(codeword_out), 32'd0);
    @(negedge clk);
    check("rst_beats_hs_state", 32'(state_out), 32'd0);
    check("rst_beats_hs_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    send(4'hD, 3'd0, 7'h66, hs);

    n = 0;
    while (busy && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
